// File: rtl/avg_stream_div.sv
// avg_stream_div: streaming averager for framed bursts of unsigned samples.
// A frame opens with start, then collects samples qualified by data_valid
// (gaps allowed), framed by data_first/data_last. The sum is divided by the
// sample count with an internal radix-2 restoring divider, one quotient bit
// per cycle.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         open a frame (sampled only in IDLE)
//   timeout_cfg   gap timeout in cycles, latched on start, 0 disables it
//   round_en      round-to-nearest, latched on start
//   data_valid    sample qualifier
//   data_first    first sample of a frame (restarts the frame in ACCUM)
//   data_last     last sample of a frame
//   data_in       unsigned sample
//   data_out      average (quotient), held until the next done or reset
//   rem_out       division remainder, held until the next done or reset
//   count_out     number of samples averaged, held until the next done or reset
//   busy          frame in progress
//   TO            one-cycle pulse: gap timeout, frame aborted
//   ovf           one-cycle pulse: too many samples, frame aborted
//   done          one-cycle pulse: data_out/rem_out/count_out updated
module avg_stream_div #(
  parameter int unsigned NOF_BITS = 32,
  parameter int unsigned CNT_BITS = 8,
  parameter int unsigned TO_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TO_BITS-1:0]  timeout_cfg,
  input  logic                round_en,
  input  logic                data_valid,
  input  logic                data_first,
  input  logic                data_last,
  input  logic [NOF_BITS-1:0] data_in,
  output logic [NOF_BITS-1:0] data_out,
  output logic [CNT_BITS-1:0] rem_out,
  output logic [CNT_BITS-1:0] count_out,
  output logic                busy,
  output logic                TO,
  output logic                ovf,
  output logic                done
);

  // Accumulator/dividend width: (2^CNT_BITS-1) samples of NOF_BITS never overflow it.
  localparam int unsigned ACC_W  = NOF_BITS + CNT_BITS;
  localparam int unsigned STEP_W = $clog2(ACC_W);
  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
  localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    ACCUM      = 2'd2,
    DIV        = 2'd3
  } state_t;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_BITS-1:0] r_cnt;
  logic [TO_BITS-1:0]  r_wait;
  logic [TO_BITS-1:0]  r_to_cfg;
  logic                r_round;

  // Divider: r_dq shifts the dividend out at the top and the quotient in at the bottom.
  logic [ACC_W-1:0]    r_dq;
  logic [CNT_BITS-1:0] r_prem;
  logic [STEP_W-1:0]   r_step;

  logic                w_sample;
  logic                w_restart;
  logic                w_gap;
  logic                w_to_hit;
  logic                w_cnt_full;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic [ACC_W-1:0]    w_dividend;
  logic [CNT_BITS:0]   w_rem_shift;
  logic                w_ge;
  logic [CNT_BITS-1:0] w_rem_nxt;
  logic [ACC_W-1:0]    w_dq_nxt;

  // Sample acceptance and frame bookkeeping.
  assign w_sample   = data_valid && ((r_state == WAIT_FIRST) || (r_state == ACCUM));
  assign w_restart  = w_sample && data_first;
  // In WAIT_FIRST a sample without data_first is discarded and counts as a gap.
  assign w_gap      = !(w_sample && ((r_state == ACCUM) || data_first));
  assign w_to_hit   = (r_to_cfg != '0) && (r_wait == (r_to_cfg - TO_BITS'(1)));
  assign w_cnt_full = (r_state == ACCUM) && w_sample && (r_cnt == CNT_MAX);

  assign w_acc_nxt  = w_restart ? ACC_W'(data_in) : (r_acc + ACC_W'(data_in));
  assign w_cnt_nxt  = w_restart ? CNT_BITS'(1) : (r_cnt + CNT_BITS'(1));
  // Adding cnt/2 before dividing turns truncation into round-to-nearest.
  assign w_dividend = w_acc_nxt + (r_round ? ACC_W'(w_cnt_nxt >> 1) : ACC_W'(0));

  // One restoring-division step.
  assign w_rem_shift = {r_prem, r_dq[ACC_W-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_cnt});
  assign w_rem_nxt   = w_ge ? CNT_BITS'(w_rem_shift - {1'b0, r_cnt})
                            : CNT_BITS'(w_rem_shift);
  assign w_dq_nxt    = {r_dq[ACC_W-2:0], w_ge};

  // Frame control, accumulation, division and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_to_cfg  <= '0;
      r_round   <= 1'b0;
      r_dq      <= '0;
      r_prem    <= '0;
      r_step    <= '0;
      data_out  <= '0;
      rem_out   <= '0;
      count_out <= '0;
      busy      <= 1'b0;
      TO        <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      TO   <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= WAIT_FIRST;
            busy     <= 1'b1;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_wait   <= '0;
            r_to_cfg <= timeout_cfg;
            r_round  <= round_en;
          end
        end

        WAIT_FIRST, ACCUM: begin
          if (w_cnt_full) begin
            // Overflow wins over data_last and restart.
            ovf     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (!w_gap) begin
            // An accepted sample always beats a coincident timeout.
            r_acc  <= w_acc_nxt;
            r_cnt  <= w_cnt_nxt;
            r_wait <= '0;
            if (data_last) begin
              r_state <= DIV;
              r_dq    <= w_dividend;
              r_prem  <= '0;
              r_step  <= '0;
            end else begin
              r_state <= ACCUM;
            end
          end else if (r_to_cfg != '0) begin
            if (w_to_hit) begin
              TO      <= 1'b1;
              busy    <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_wait <= r_wait + TO_BITS'(1);
            end
          end
        end

        DIV: begin
          r_dq   <= w_dq_nxt;
          r_prem <= w_rem_nxt;
          r_step <= r_step + STEP_W'(1);
          if (r_step == LAST_STEP) begin
            // Quotient is bounded by the sample maximum, so the low bits are exact.
            data_out  <= w_dq_nxt[NOF_BITS-1:0];
            rem_out   <= w_rem_nxt;
            count_out <= r_cnt;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avg_stream_div.sv
// Directed bench for avg_stream_div with NOF_BITS=8, CNT_BITS=4, TO_BITS=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_avg_stream_div;

  localparam int unsigned NB = 8;
  localparam int unsigned CB = 4;
  localparam int unsigned TB = 4;
  localparam int LAT = NB + CB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [TB-1:0] timeout_cfg = '0;
  logic          round_en = 1'b0;
  logic          data_valid = 1'b0;
  logic          data_first = 1'b0;
  logic          data_last = 1'b0;
  logic [NB-1:0] data_in = '0;
  logic [NB-1:0] data_out;
  logic [CB-1:0] rem_out;
  logic [CB-1:0] count_out;
  logic          busy;
  logic          TO;
  logic          ovf;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  avg_stream_div #(
    .NOF_BITS (NB),
    .CNT_BITS (CB),
    .TO_BITS  (TB)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .timeout_cfg (timeout_cfg),
    .round_en    (round_en),
    .data_valid  (data_valid),
    .data_first  (data_first),
    .data_last   (data_last),
    .data_in     (data_in),
    .data_out    (data_out),
    .rem_out     (rem_out),
    .count_out   (count_out),
    .busy        (busy),
    .TO          (TO),
    .ovf         (ovf),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [TB-1:0] cfg, input logic rnd);
    start = 1'b1;
    timeout_cfg = cfg;
    round_en = rnd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [NB-1:0] d, input logic f, input logic l);
    data_valid = 1'b1;
    data_first = f;
    data_last  = l;
    data_in    = d;
    @(negedge clk);
    data_valid = 1'b0;
    data_first = 1'b0;
    data_last  = 1'b0;
  endtask

  // Called right after the last sample; expects done LAT edges later.
  task automatic expect_result(input string tag, input int q, input int r, input int c,
                               input bit b2b);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_data_out"}, 32'(data_out), 32'(q));
    check({tag, "_rem_out"}, 32'(rem_out), 32'(r));
    check({tag, "_count_out"}, 32'(count_out), 32'(c));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (b2b) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    if (b2b) check({tag, "_b2b_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int cyc;
    int seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({data_out, rem_out, count_out, busy, TO, ovf, done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic average 101/4, with one gap mid-frame
    start_frame(4'd0, 1'b0);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    send(8'd10, 1'b1, 1'b0);
    send(8'd20, 1'b0, 1'b0);
    @(negedge clk);
    send(8'd30, 1'b0, 1'b0);
    send(8'd41, 1'b0, 1'b1);
    check("t1_busy_in_div", 32'(busy), 32'd1);
    expect_result("t1", 25, 1, 4, 1'b0);

    // Rounding: D = 101 + 2 = 103
    start_frame(4'd0, 1'b1);
    send(8'd10, 1'b1, 1'b0);
    send(8'd20, 1'b0, 1'b0);
    send(8'd30, 1'b0, 1'b0);
    send(8'd41, 1'b0, 1'b1);
    expect_result("t2", 25, 3, 4, 1'b0);

    // Single max sample, then start on the done cycle
    start_frame(4'd0, 1'b0);
    send(8'd255, 1'b1, 1'b1);
    expect_result("t3", 255, 0, 1, 1'b1);
    send(8'd7, 1'b1, 1'b1);
    expect_result("t3b", 7, 0, 1, 1'b0);

    // Timeout 3 with valid samples lacking data_first (discarded as gaps)
    start_frame(4'd3, 1'b0);
    data_valid = 1'b1;
    cyc = 0;
    while (TO !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    data_valid = 1'b0;
    check("t4_to_edge", 32'(cyc), 32'd3);
    check("t4_busy_at_to", 32'(busy), 32'd0);
    check("t4_done_at_to", 32'(done), 32'd0);
    check("t4_data_held", 32'(data_out), 32'd7);
    @(negedge clk);
    check("t4_to_pulse", 32'(TO), 32'd0);

    // Timeout disabled: 50 quiet cycles, then finish the frame (10/2)
    start_frame(4'd0, 1'b0);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (TO === 1'b1) seen++;
    end
    check("t4b_no_to", 32'(seen), 32'd0);
    check("t4b_still_busy", 32'(busy), 32'd1);
    send(8'd4, 1'b1, 1'b0);
    send(8'd6, 1'b0, 1'b1);
    expect_result("t4b", 5, 0, 2, 1'b0);

    // 15 x 255 with 2-cycle gaps, timeout 3, rounding: D = 3825 + 7
    start_frame(4'd3, 1'b1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      send(8'd255, 1'(i == 0), 1'(i == 14));
      if (i < 14) begin
        repeat (2) begin
          @(negedge clk);
          if (TO === 1'b1) seen++;
        end
      end
    end
    check("t5_no_to", 32'(seen), 32'd0);
    expect_result("t5", 255, 7, 15, 1'b0);

    // 3-cycle gap mid-frame times out
    start_frame(4'd3, 1'b0);
    send(8'd1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("t5b_no_to_yet", 32'(TO), 32'd0);
    @(negedge clk);
    check("t5b_to", 32'(TO), 32'd1);
    check("t5b_busy", 32'(busy), 32'd0);

    // data_first mid-frame restarts: (50+70)/2
    start_frame(4'd0, 1'b0);
    send(8'd100, 1'b1, 1'b0);
    send(8'd50, 1'b1, 1'b0);
    send(8'd70, 1'b0, 1'b1);
    expect_result("t6", 60, 0, 2, 1'b0);

    // 16 samples: overflow on the 16th, last flag on it must lose
    for (int run = 0; run < 2; run++) begin
      start_frame(4'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
        send(8'd1, 1'(i == 0), 1'(run == 1 && i == 15));
        if (i == 14) check("t7_no_early_ovf", 32'(ovf), 32'd0);
      end
      check("t7_ovf", 32'(ovf), 32'd1);
      check("t7_busy", 32'(busy), 32'd0);
      check("t7_done", 32'(done), 32'd0);
      seen = 0;
      repeat (LAT + 4) begin
        @(negedge clk);
        if (done === 1'b1 || ovf === 1'b1) seen++;
      end
      check("t7_quiet_after", 32'(seen), 32'd0);
      check("t7_data_held", 32'(data_out), 32'd60);
    end

    // Reset during DIV
    start_frame(4'd0, 1'b0);
    send(8'd9, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t8_reset_outputs", 32'({data_out, rem_out, count_out, busy, TO, ovf, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("t8_idle_after_reset", 32'(seen), 32'd0);
    start_frame(4'd0, 1'b0);
    send(8'd3, 1'b1, 1'b1);
    expect_result("t8", 3, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
